// File: rtl/ex3_to_bcd_packer.sv
// ex3_to_bcd_packer
//   Receives one Excess-3 digit per handshake and subtracts 3 to recover the
//   BCD digit. Codes outside 3..12 are stored as nibble F and flagged.
//   DIGITS decoded digits are packed into one BCD word, with the first digit
//   in the most significant nibble. The packed word is then offered on a
//   valid/ready output port.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   in_valid      in_ex3 holds a digit
//   in_ready      block accepts a digit this cycle (FILL and not in reset)
//   in_ex3        Excess-3 coded digit
//   out_valid     out_bcd / out_err / out_err_mask hold a complete word
//   out_ready     consumer takes the word this cycle
//   out_bcd       packed BCD word, 4*DIGITS bits
//   out_err_mask  bit i set = nibble i came from an invalid code
//   out_err       OR of out_err_mask
module ex3_to_bcd_packer #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_ex3,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic [DIGITS-1:0]     out_err_mask,
   output logic                  out_err
);

   localparam int CW = $clog2(DIGITS);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [CW-1:0]   pos;
   logic            accept, handshake, code_ok;
   logic [3:0]      nib;

   // decode
   always_comb begin
      code_ok = (in_ex3 >= 4'd3) && (in_ex3 <= 4'd12);
      nib     = code_ok ? (in_ex3 - 4'd3) : 4'hF;
   end

   // next state / handshake decode
   always_comb begin
      state_nxt = state;
      count_nxt = count;
      // in_ready is forced low during reset so no digit is taken that cycle
      in_ready  = (state == FILL) && !rst;
      out_valid = (state == HOLD);
      accept    = in_valid && in_ready;
      handshake = (state == HOLD) && out_ready;
      // first digit of a word lands in the top nibble
      pos       = LAST - count;
      case (state)
         FILL: begin
            if (accept) begin
               if (count == LAST) begin
                  state_nxt = HOLD;
                  count_nxt = '0;
               end else begin
                  count_nxt = count + CW'(1);
               end
            end
         end
         HOLD: begin
            if (out_ready) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FILL;
         count        <= '0;
         out_bcd      <= '0;
         out_err_mask <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         // accept and handshake are never active in the same cycle
         if (handshake) out_err_mask <= '0;
         for (int i = 0; i < DIGITS; i++) begin
            if (accept && pos == CW'(i)) begin
               out_bcd[4*i +: 4] <= nib;
               out_err_mask[i]   <= !code_ok;
            end
         end
      end
   end

   assign out_err = |out_err_mask;

endmodule

// File: tb/tb_ex3_to_bcd_packer.sv
module tb_ex3_to_bcd_packer;

   localparam int D = 4;

   logic           clk = 1'b0;
   logic           rst, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [3:0]     in_ex3;
   logic [4*D-1:0] out_bcd;
   logic [D-1:0]   out_err_mask;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: raw codes of the word being collected / held
   bit m_hold;
   int q[$];

   ex3_to_bcd_packer #(.DIGITS(D)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_ex3(in_ex3),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_bcd(out_bcd), .out_err_mask(out_err_mask), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic int dec(input int c);
      return (c >= 3 && c <= 12) ? c - 3 : 15;
   endfunction

   function automatic logic [63:0] m_word();
      logic [63:0] w = 0;
      foreach (q[k]) w = w * 16 + 64'(dec(q[k]));
      return w;
   endfunction

   function automatic logic [63:0] m_mask();
      logic [63:0] m = 0;
      foreach (q[k]) if (dec(q[k]) == 15) m[D-1-k] = 1'b1;
      return m;
   endfunction

   // one clock cycle: drive, check at negedge, advance model at posedge
   task automatic cyc(input logic v, input logic [3:0] d, input logic r, input logic rs);
      logic [63:0] mm;
      in_valid = v; in_ex3 = d; out_ready = r; rst = rs;
      @(negedge clk);
      mm = m_mask();
      chk("in_ready", in_ready, !m_hold && !rs);
      chk("out_valid", out_valid, m_hold);
      chk("err_mask", out_err_mask, mm);
      chk("out_err", out_err, |mm);
      if (m_hold) chk("out_bcd", out_bcd, m_word());
      @(posedge clk);
      if (rs) begin
         m_hold = 0; q.delete();
      end else if (!m_hold) begin
         if (v) q.push_back(int'(d));
         if (q.size() == D) m_hold = 1;
      end else if (r) begin
         m_hold = 0; q.delete();
      end
      #1;
   endtask

   task automatic word(input logic [3:0] a, b, c, e);
      cyc(1, a, 1, 0); cyc(1, b, 1, 0); cyc(1, c, 1, 0); cyc(1, e, 1, 0);
   endtask

   // called right after the completing edge
   task automatic wchk(input string tag, input logic [15:0] bcd, input logic [3:0] mask);
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_bcd"},   out_bcd, bcd);
      chk({tag, "_mask"},  out_err_mask, mask);
      chk({tag, "_err"},   out_err, |mask);
   endtask

   initial begin
      rst = 1; in_valid = 0; in_ex3 = 0; out_ready = 0;
      m_hold = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bcd", out_bcd, 0);
      chk("rst_mask", out_err_mask, 0);
      chk("rst_err", out_err, 0);
      rst = 0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // basic word, valid one cycle after 4th accept
      word(4'h7, 4'h8, 4'h9, 4'hC);
      wchk("w1", 16'h4569, 4'b0000);
      cyc(0, 0, 1, 0);

      // invalid codes
      word(4'h3, 4'h2, 4'hC, 4'hF);
      wchk("w2", 16'h0F9F, 4'b0101);
      cyc(1, 4'h4, 1, 0);              // handshake cycle: digit not taken
      word(4'h4, 4'h4, 4'h4, 4'h4);
      wchk("w3", 16'h1111, 4'b0000);
      cyc(0, 0, 1, 0);

      // backpressure
      word(4'h5, 4'h6, 4'h7, 4'h8);
      wchk("bp", 16'h2345, 4'b0000);
      repeat (5) cyc(1, 4'h9, 0, 0);
      chk("bp_stable", out_bcd, 16'h2345);
      chk("bp_in_ready", in_ready, 0);
      cyc(1, 4'h9, 1, 0);              // handshake
      cyc(1, 4'h0, 1, 0);              // invalid first digit -> top nibble
      chk("bp_next_nib3_mask", out_err_mask, 4'b1000);
      cyc(1, 4'h4, 1, 0); cyc(1, 4'h4, 1, 0); cyc(1, 4'h4, 1, 0);
      wchk("bp_next", 16'hF111, 4'b1000);
      cyc(0, 0, 1, 0);

      // mid-word reset
      cyc(1, 4'h6, 1, 0); cyc(1, 4'h7, 1, 0);
      cyc(1, 4'h8, 1, 1);
      word(4'hB, 4'hA, 4'h9, 4'h8);
      wchk("mwr", 16'h8765, 4'b0000);
      cyc(0, 0, 1, 0);

      // bubbles
      cyc(1, 4'h3, 1, 0); cyc(0, 4'hE, 1, 0);
      cyc(1, 4'h4, 1, 0); cyc(0, 4'hE, 1, 0);
      cyc(1, 4'h5, 1, 0); cyc(0, 4'hE, 1, 0);
      chk("bub_not_yet", out_valid, 0);
      cyc(1, 4'h6, 1, 0);
      wchk("bub", 16'h0123, 4'b0000);
      cyc(0, 0, 1, 0);

      // full code sweep
      word(4'h0, 4'h1, 4'h2, 4'h3);  wchk("sw0", 16'hFFF0, 4'b1110); cyc(0, 0, 1, 0);
      word(4'h4, 4'h5, 4'h6, 4'h7);  wchk("sw1", 16'h1234, 4'b0000); cyc(0, 0, 1, 0);
      word(4'h8, 4'h9, 4'hA, 4'hB);  wchk("sw2", 16'h5678, 4'b0000); cyc(0, 0, 1, 0);
      word(4'hC, 4'hD, 4'hE, 4'hF);  wchk("sw3", 16'h9FFF, 4'b0111); cyc(0, 0, 1, 0);

      // randomized traffic against the model
      repeat (600)
         cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
